add_sub_sequencer: RTL and testbench

//  Control stage around the 8-bit ripple adder/subtractor.
//  - Upstream: accepts operations over a valid/ready handshake and drives a/b/mode into the datapath.
//  - Downstream: captures sum/carry, derives status flags and presents the result over a valid/ready handshake.
//  - Keeps an internal accumulator so chained add/sub operations need no external feedback.

---
 rtl/add_sub_sequencer_pkg.sv | 48 ++++
 rtl/add_sub_sequencer_circuit.sv | 26 ++
 rtl/add_sub_sequencer.sv | 124 ++++++++++++
 tb/tb_add_sub_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_sequencer_pkg.sv
// Shared types for the add/sub sequencer: op encodings, FSM states,
// captured-operation and result bundles, and the flag helper.
package add_sub_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_SUB    = 2'b01,
        OP_ACC    = 2'b10,
        OP_ACCSUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    localparam int DW = 8;

    typedef struct packed {
        op_e           op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } op_t;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          carry;
        logic          zero;
        logic          ovf;
    } res_t;

    // bm is operand B after the subtract inversion, as seen by the adder.
    function automatic res_t mk_flags(
        input logic [DW-1:0] a,
        input logic [DW-1:0] bm,
        input logic [DW-1:0] sum,
        input logic          co
    );
        res_t r;
        r.res   = sum;
        r.carry = co;
        r.zero  = (sum == '0);
        r.ovf   = (a[DW-1] == bm[DW-1]) & (sum[DW-1] != a[DW-1]);
        return r;
    endfunction

endpackage

// File: rtl/add_sub_sequencer_circuit.sv
// 8-bit ripple adder/subtractor: mode 0 adds, mode 1 computes a - b
// as a + ~b + 1. o8 is the carry out of bit 7.
module add_sub_circuit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       mode,
    output logic [7:0] s,
    output logic       o8
);

    logic [7:0] bx;

    assign bx = b ^ {8{mode}};

    always_comb begin
        logic cy;
        s  = '0;
        cy = mode;
        for (int i = 0; i < 8; i++) begin
            s[i] = a[i] ^ bx[i] ^ cy;
            cy   = (a[i] & bx[i]) | (cy & (a[i] ^ bx[i]));
        end
        o8 = cy;
    end

endmodule

// File: rtl/add_sub_sequencer.sv
// Handshaked control stage around the ripple adder/subtractor with an
// internal accumulator and a completed-operation counter.
module add_sub_sequencer
    import add_sub_sequencer_pkg::*;
#(
    parameter logic [7:0] ACC_INIT = 8'h00,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_res,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [7:0]       acc,
    output logic [CNT_W-1:0] op_count
);

    state_e           state_q, state_d;
    op_t              op_q, op_d;
    res_t             res_q, res_d;
    logic [7:0]       acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0] dp_sum;
    logic       dp_o8;
    logic [7:0] dp_bm;
    res_t       dp_res;

    add_sub_circuit u_dp (
        .a    (op_q.a),
        .b    (op_q.b),
        .mode (op_q.op[0]),
        .s    (dp_sum),
        .o8   (dp_o8)
    );

    assign dp_bm  = op_q.b ^ {8{op_q.op[0]}};
    assign dp_res = mk_flags(op_q.a, dp_bm, dp_sum, dp_o8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            res_q   <= '0;
            acc_q   <= ACC_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        res_d     = res_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d.op = op_e'(in_op);
                    op_d.a  = in_op[1] ? acc_q : in_a;
                    op_d.b  = in_b;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = dp_res;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                    acc_d   = res_q.res;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Clear overrides any result write-back in the same cycle.
        if (acc_clr) acc_d = ACC_INIT;
    end

    assign out_res   = res_q.res;
    assign out_carry = res_q.carry;
    assign out_zero  = res_q.zero;
    assign out_ovf   = res_q.ovf;
    assign acc       = acc_q;
    assign op_count  = cnt_q;

    a_hold_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == ST_HOLD && !out_ready)
            |=> (state_q == ST_HOLD && $stable(res_q) && $stable(cnt_q))
    );

    a_hold_exit: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == ST_HOLD && out_ready) |=> (state_q == ST_IDLE)
    );

    a_exec_one: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == ST_EXEC) |=> (state_q == ST_HOLD)
    );

endmodule

// File: tb/tb_add_sub_sequencer.sv
// Directed bench for add_sub_sequencer: arithmetic flags, accumulator
// chaining and clear, backpressure, and reset during execution.
module tb_add_sub_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [7:0]  in_a = 8'h00;
    logic [7:0]  in_b = 8'h00;
    logic        acc_clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_res;
    logic        out_carry;
    logic        out_zero;
    logic        out_ovf;
    logic [7:0]  acc;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    add_sub_sequencer #(
        .ACC_INIT (8'h00),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .acc       (acc),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one op through accept, execute and handshake; returns what
    // was seen while out_valid was high and the accept-to-valid cycles.
    task automatic issue(
        input  logic [1:0] op,
        input  logic [7:0] a,
        input  logic [7:0] b,
        input  logic       clr,
        output logic [7:0] r,
        output logic       c,
        output logic       z,
        output logic       v,
        output int         lat
    );
        int n;
        in_op = op;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        r = out_res;
        c = out_carry;
        z = out_zero;
        v = out_ovf;
        out_ready = 1'b1;
        acc_clr = clr;
        tick();
        out_ready = 1'b0;
        acc_clr = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        checks++;
        if ({out_res, out_carry, out_zero, out_ovf} !== 11'h000) begin
            errors++;
            $display("FAIL rst_out got %h/%b%b%b want 00/000",
                     out_res, out_carry, out_zero, out_ovf);
        end
        checks++;
        if (acc !== 8'h00 || op_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_acc_cnt got %h/%0d want 00/0", acc, op_count);
        end
    endtask

    task automatic test_arith();
        logic [7:0] r;
        logic       c, z, v;
        int         lat;
        issue(2'b00, 8'h7F, 8'h01, 1'b0, r, c, z, v, lat);
        checks++;
        if ({r, c, z, v} !== {8'h80, 3'b001}) begin
            errors++;
            $display("FAIL add_7f_01 got %h c%b z%b v%b want 80 c0 z0 v1",
                     r, c, z, v);
        end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL add_latency got %0d want 1", lat);
        end
        checks++;
        if (op_count !== 16'd1 || acc !== 8'h80) begin
            errors++;
            $display("FAIL add_cnt_acc got %0d/%h want 1/80", op_count, acc);
        end
        issue(2'b01, 8'h05, 8'h05, 1'b0, r, c, z, v, lat);
        checks++;
        if ({r, c, z, v} !== {8'h00, 3'b110}) begin
            errors++;
            $display("FAIL sub_05_05 got %h c%b z%b v%b want 00 c1 z1 v0",
                     r, c, z, v);
        end
        issue(2'b01, 8'h00, 8'h01, 1'b0, r, c, z, v, lat);
        checks++;
        if ({r, c, z, v} !== {8'hFF, 3'b000}) begin
            errors++;
            $display("FAIL sub_00_01 got %h c%b z%b v%b want ff c0 z0 v0",
                     r, c, z, v);
        end
        issue(2'b01, 8'h80, 8'h01, 1'b0, r, c, z, v, lat);
        checks++;
        if ({r, c, z, v} !== {8'h7F, 3'b101}) begin
            errors++;
            $display("FAIL sub_80_01 got %h c%b z%b v%b want 7f c1 z0 v1",
                     r, c, z, v);
        end
        checks++;
        if (op_count !== 16'd4) begin
            errors++;
            $display("FAIL arith_cnt got %0d want 4", op_count);
        end
    endtask

    task automatic test_acc();
        logic [7:0] r;
        logic       c, z, v;
        int         lat;
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        checks++;
        if (acc !== 8'h00) begin
            errors++;
            $display("FAIL acc_clr got %h want 00", acc);
        end
        issue(2'b10, 8'h55, 8'hF0, 1'b0, r, c, z, v, lat);
        checks++;
        if ({r, c} !== {8'hF0, 1'b0} || acc !== 8'hF0) begin
            errors++;
            $display("FAIL acc_f0 got %h c%b acc %h want f0 c0 acc f0",
                     r, c, acc);
        end
        issue(2'b10, 8'hAA, 8'h20, 1'b0, r, c, z, v, lat);
        checks++;
        if ({r, c} !== {8'h10, 1'b1} || acc !== 8'h10) begin
            errors++;
            $display("FAIL acc_20 got %h c%b acc %h want 10 c1 acc 10",
                     r, c, acc);
        end
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        issue(2'b10, 8'h00, 8'hF0, 1'b0, r, c, z, v, lat);
        issue(2'b10, 8'h00, 8'h20, 1'b1, r, c, z, v, lat);
        checks++;
        if (r !== 8'h10 || acc !== 8'h00) begin
            errors++;
            $display("FAIL acc_clr_hs got %h acc %h want 10 acc 00", r, acc);
        end
        issue(2'b11, 8'h33, 8'h01, 1'b0, r, c, z, v, lat);
        checks++;
        if ({r, c, z, v} !== {8'hFF, 3'b000} || acc !== 8'hFF) begin
            errors++;
            $display("FAIL accsub got %h c%b z%b v%b acc %h want ff 000 acc ff",
                     r, c, z, v, acc);
        end
        checks++;
        if (op_count !== 16'd9) begin
            errors++;
            $display("FAIL acc_cnt got %0d want 9", op_count);
        end
    endtask

    task automatic test_back_to_back();
        in_op = 2'b00;
        in_a = 8'h12;
        in_b = 8'h34;
        in_valid = 1'b1;
        tick();
        in_a = 8'h01;
        in_b = 8'h02;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_res !== 8'h46) begin
            errors++;
            $display("FAIL bp_first got v%b %h want v1 46", out_valid, out_res);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_res !== 8'h46 || op_count !== 16'd9) begin
                errors++;
                $display("FAIL bp_hold%0d got v%b r%b %h cnt %0d want v1 r0 46 cnt 9",
                         i, out_valid, in_ready, out_res, op_count);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            op_count !== 16'd10 || acc !== 8'h46) begin
            errors++;
            $display("FAIL bp_release got v%b r%b cnt %0d acc %h want v0 r1 10 46",
                     out_valid, in_ready, op_count, acc);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept got r%b v%b want r0 v0",
                     in_ready, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_res !== 8'h03) begin
            errors++;
            $display("FAIL bp_second got v%b %h want v1 03", out_valid, out_res);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (op_count !== 16'd11) begin
            errors++;
            $display("FAIL bp_cnt got %0d want 11", op_count);
        end
    endtask

    task automatic test_reset_exec();
        logic [7:0] r;
        logic       c, z, v;
        int         lat;
        in_op = 2'b00;
        in_a = 8'h10;
        in_b = 8'h20;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || acc !== 8'h00 ||
            op_count !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_exec got v%b acc %h cnt %0d r%b want v0 00 0 r1",
                     out_valid, acc, op_count, in_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_res !== 8'h00) begin
            errors++;
            $display("FAIL rst_drop got v%b %h want v0 00", out_valid, out_res);
        end
        issue(2'b00, 8'h03, 8'h04, 1'b0, r, c, z, v, lat);
        checks++;
        if (r !== 8'h07 || lat !== 1 || op_count !== 16'd1) begin
            errors++;
            $display("FAIL post_rst got %h lat %0d cnt %0d want 07 1 1",
                     r, lat, op_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        #1;
        test_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_arith();
        test_acc();
        test_back_to_back();
        test_reset_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
